down_counter_timer: RTL and testbench

- Loadable down-counter timer; the decrementing counterpart of the team's 4-bit up counter.
- Host loads a start value through a valid/ready handshake, starts it, and can pause, resume or abort it.
- Pulses `done` when the count expires; optionally auto-reloads for periodic ticks.
- Sits beside the up counter as the timeout/interval source for control logic.

---
 rtl/down_counter_timer.sv | 211 +++++++++++++++++++++
 tb/tb_down_counter_timer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// down_counter_timer
// Loadable down-counter timer. The host loads a start value through a
// valid/ready handshake. It then starts the count and can pause, resume or
// abort it. A one-cycle `done` pulse marks expiry, which happens on the tick
// after the count reaches 0. With the periodic flag set, the counter reloads
// on expiry and keeps running, which gives interval ticks.
//
// Optional feature: define DOWN_COUNTER_TIMER_PRESCALE_EN to decrement only
// once every PRESCALE cycles while RUNNING. Without it, RUNNING ticks every
// cycle and no prescale logic exists.
//
// Every output comes straight from a register.

module down_counter_timer #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             periodic,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADED  = 2'd1,
        ST_RUNNING = 2'd2,
        ST_PAUSED  = 2'd3
    } state_t;

    // Registered state and outputs
    state_t            r_state;
    logic [WIDTH-1:0]  r_count;
    logic [WIDTH-1:0]  r_reload;
    logic              r_periodic;
    logic              r_done;
    logic              r_busy;
    logic              r_load_ready;

    // Next-state values from the combinational process
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  w_count_nxt;
    logic [WIDTH-1:0]  w_reload_nxt;
    logic              w_periodic_nxt;
    logic              w_done_nxt;

    logic              w_accept;
    logic              w_tick;

    // A load is taken only while the handshake says we can take one.
    assign w_accept = load_valid & r_load_ready;

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
    localparam int unsigned PW = $clog2(PRESCALE);

    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          w_go;
    logic          w_run_adv;

    // The prescale counter restarts whenever the timer enters RUNNING. The
    // conditions for entering RUNNING repeat the FSM priorities.
    assign w_go = ((r_state == ST_LOADED) & start & ~stop & ~w_accept)
                | ((r_state == ST_PAUSED) & start & ~stop);

    // The prescale counter advances only while running without a pause request.
    assign w_run_adv = (r_state == ST_RUNNING) & ~stop;

    // A tick fires on the last cycle of each prescale period.
    assign w_tick = (r_presc == PW'(PRESCALE - 1));

    // Next value of the prescale counter: clear on entry, wrap on tick, hold otherwise
    always_comb begin
        w_presc_nxt = r_presc;
        if (w_go) begin
            w_presc_nxt = {PW{1'b0}};
        end else if (w_run_adv) begin
            if (w_tick) begin
                w_presc_nxt = {PW{1'b0}};
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end else begin
            w_presc_nxt = r_presc;
        end
    end

    // Prescale counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_presc <= {PW{1'b0}};
        end else begin
            r_presc <= w_presc_nxt;
        end
    end
`else
    // Every RUNNING cycle is a tick. PRESCALE only appears here so the
    // expression references it, and the expression folds to a constant 1.
    assign w_tick = 1'b1 | (PRESCALE == 32'd0);
`endif

    // Next-state and next-output logic. Priority: accepted load > stop > start.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_reload_nxt   = r_reload;
        w_periodic_nxt = r_periodic;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = ST_LOADED;
                    w_count_nxt    = load_value;
                    w_reload_nxt   = load_value;
                    w_periodic_nxt = periodic;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_LOADED: begin
                if (w_accept) begin
                    w_state_nxt    = ST_LOADED;
                    w_count_nxt    = load_value;
                    w_reload_nxt   = load_value;
                    w_periodic_nxt = periodic;
                end else if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    // The count is not decremented on the start edge itself.
                    w_state_nxt = ST_RUNNING;
                end else begin
                    w_state_nxt = ST_LOADED;
                end
            end

            ST_RUNNING: begin
                if (stop) begin
                    // A stop also overrides an expiry on the same edge. The
                    // held 0 then expires on the first tick after resume.
                    w_state_nxt = ST_PAUSED;
                end else if (w_tick) begin
                    if (r_count != {WIDTH{1'b0}}) begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end else begin
                        w_done_nxt = 1'b1;
                        if (r_periodic) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    w_state_nxt = ST_RUNNING;
                end
            end

            ST_PAUSED: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_RUNNING;
                end else begin
                    w_state_nxt = ST_PAUSED;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, count and output registers. busy and load_ready are derived
    // from the next state so that they always agree with `state`.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= {WIDTH{1'b0}};
            r_reload     <= {WIDTH{1'b0}};
            r_periodic   <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_reload     <= w_reload_nxt;
            r_periodic   <= w_periodic_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= (w_state_nxt == ST_RUNNING);
            r_load_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOADED);
        end
    end

    assign count      = r_count;
    assign state      = r_state;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed testbench for down_counter_timer. Expected values are hand-derived.
// With DOWN_COUNTER_TIMER_PRESCALE_EN defined, each decrement tick lasts
// PRESCALE cycles, and a prescale-specific check is added.

module tb_down_counter_timer;

    localparam int WIDTH    = 4;
    localparam int PRESCALE = 4;
`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
    localparam int TP = PRESCALE;
`else
    localparam int TP = 1;
`endif

    logic             clock;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             periodic;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             busy;
    logic             done;

    int n_checks;
    int n_pass;

    down_counter_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .periodic   (periodic),
        .start      (start),
        .stop       (stop),
        .count      (count),
        .state      (state),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock edge, then settle so that outputs are sampled away from the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One decrement tick's worth of cycles.
    task automatic tick_wait();
        for (int i = 0; i < TP; i++) cyc();
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v, input logic p);
        load_valid = 1'b1;
        load_value = v;
        periodic   = p;
        cyc();
        load_valid = 1'b0;
        periodic   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_value = 4'd0;
        periodic   = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);

        // One-shot load 5
        do_load(4'd5, 1'b0);
        check("os_load_state", 32'(state), 32'd1);
        check("os_load_count", 32'(count), 32'd5);
        do_start();
        check("os_run_state", 32'(state), 32'd2);
        check("os_run_count", 32'(count), 32'd5);
        check("os_run_busy",  32'(busy),  32'd1);
        check("os_run_ready", 32'(load_ready), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick_wait();
            check("os_count", 32'(count), 32'(5 - k));
            check("os_done_low", 32'(done), 32'd0);
        end
        tick_wait();
        check("os_done",  32'(done),  32'd1);
        check("os_state", 32'(state), 32'd0);
        check("os_zero",  32'(count), 32'd0);
        check("os_ready", 32'(load_ready), 32'd1);
        check("os_busy",  32'(busy),  32'd0);
        cyc();
        check("os_done_once", 32'(done), 32'd0);

        // Periodic load 2
        do_load(4'd2, 1'b1);
        do_start();
        check("per_count0", 32'(count), 32'd2);
        for (int i = 1; i <= 12; i++) begin
            tick_wait();
            check("per_count", 32'(count), 32'(2 - (i % 3)));
            check("per_done",  32'(done),  32'((i % 3) == 0));
            check("per_busy",  32'(busy),  32'd1);
        end
        do_stop();
        do_stop();
        check("per_abort_state", 32'(state), 32'd0);

        // Pause and resume: load 7, pause at 4
        do_load(4'd7, 1'b0);
        do_start();
        for (int i = 0; i < 3; i++) tick_wait();
        check("pr_count4", 32'(count), 32'd4);
        do_stop();
        check("pr_paused", 32'(state), 32'd3);
        check("pr_busy0",  32'(busy),  32'd0);
        for (int i = 0; i < 5; i++) cyc();
        check("pr_hold",   32'(count), 32'd4);
        check("pr_hold_st", 32'(state), 32'd3);
        check("pr_ready0", 32'(load_ready), 32'd0);
        do_start();
        check("pr_resume", 32'(state), 32'd2);
        check("pr_resume_cnt", 32'(count), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            tick_wait();
            check("pr_count", 32'(count), 32'(4 - k));
            check("pr_done_low", 32'(done), 32'd0);
        end
        tick_wait();
        check("pr_done",  32'(done),  32'd1);
        check("pr_state", 32'(state), 32'd0);

        // Load 0: expires on the first tick
        do_load(4'd0, 1'b0);
        do_start();
        check("z_count", 32'(count), 32'd0);
        check("z_done_low", 32'(done), 32'd0);
        tick_wait();
        check("z_done",  32'(done),  32'd1);
        check("z_state", 32'(state), 32'd0);

        // Load 15: 16-tick interval, no wrap to 15
        do_load(4'd15, 1'b0);
        do_start();
        for (int i = 0; i < 15; i++) tick_wait();
        check("max_zero", 32'(count), 32'd0);
        check("max_done_low", 32'(done), 32'd0);
        tick_wait();
        check("max_done",  32'(done),  32'd1);
        check("max_nowrap", 32'(count), 32'd0);
        cyc();
        check("max_nowrap2", 32'(count), 32'd0);
        check("max_state", 32'(state), 32'd0);

        // start+stop together in RUNNING: stop wins
        do_load(4'd3, 1'b0);
        do_start();
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_state", 32'(state), 32'd3);
        check("ss_count", 32'(count), 32'd3);
        do_stop();
        check("ss_idle", 32'(state), 32'd0);

        // load+start together in LOADED: load wins
        do_load(4'd6, 1'b0);
        load_valid = 1'b1;
        load_value = 4'd9;
        start      = 1'b1;
        cyc();
        load_valid = 1'b0;
        start      = 1'b0;
        check("ls_state", 32'(state), 32'd1);
        check("ls_count", 32'(count), 32'd9);

        // load_valid in RUNNING is ignored
        do_start();
        load_valid = 1'b1;
        load_value = 4'd2;
        check("rl_ready", 32'(load_ready), 32'd0);
        cyc();
        load_valid = 1'b0;
        check("rl_state", 32'(state), 32'd2);
        check("rl_count", 32'(count), 32'((TP == 1) ? 8 : 9));
        do_stop();
        do_stop();

        // stop on the expiry edge: PAUSED at 0 with no done, then expiry after resume
        do_load(4'd1, 1'b0);
        do_start();
        tick_wait();
        check("se_zero", 32'(count), 32'd0);
        for (int i = 0; i < TP - 1; i++) cyc();
        do_stop();
        check("se_state", 32'(state), 32'd3);
        check("se_nodone", 32'(done), 32'd0);
        do_start();
        check("se_resume", 32'(state), 32'd2);
        tick_wait();
        check("se_done",  32'(done),  32'd1);
        check("se_idle",  32'(state), 32'd0);

        // Reset in RUNNING at count 3
        do_load(4'd5, 1'b0);
        do_start();
        tick_wait();
        tick_wait();
        check("mr_count3", 32'(count), 32'd3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mr_count", 32'(count), 32'd0);
        check("mr_state", 32'(state), 32'd0);
        check("mr_done",  32'(done),  32'd0);
        check("mr_ready", 32'(load_ready), 32'd1);
        check("mr_busy",  32'(busy),  32'd0);

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
        // PRESCALE=4, load 1: done after 8 cycles
        do_load(4'd1, 1'b0);
        do_start();
        for (int i = 1; i <= 7; i++) begin
            cyc();
            check("ps_done_low", 32'(done), 32'd0);
        end
        cyc();
        check("ps_done", 32'(done), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
